// File: rtl/pedestrian_signal_controller.sv
// Pedestrian WALK / DON'T-WALK head slaved to the vehicle lights bus.
// Define PED_FLASH_EN to flash DON'T-WALK during the clearance phase.
module pedestrian_signal_controller #(
    parameter int WALK_TICKS  = 60_000_000,
    parameter int CLEAR_TICKS = 30_000_000,
    parameter int FLASH_HALF  = 5_000_000,
    parameter int TW          = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lights,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       ped_wait,
    output logic       fault
);

    // state      | meaning
    // S_DONT_WALK| steady DON'T-WALK, waiting for red_rise with a request
    // S_WALK     | timed WALK phase, aborted if vehicle leaves RED
    // S_CLEAR    | clearance phase, DON'T-WALK (optionally flashing)
    typedef enum logic [1:0] {
        S_DONT_WALK = 2'd0,
        S_WALK      = 2'd1,
        S_CLEAR     = 2'd2
    } state_t;

    localparam logic [2:0] L_RED        = 3'b100;
    localparam logic [2:0] L_RED_YELLOW = 3'b110;
    localparam logic [2:0] L_GREEN      = 3'b001;
    localparam logic [2:0] L_YELLOW     = 3'b010;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            btn_s1;
    logic            btn_s2;
    logic            btn_s3;
    logic [2:0]      lights_q;
    logic            req;
    logic            fault_q;
    logic            walk_q;
    logic            dont_walk_q;
    logic            red_now;
    logic            red_rise;
    logic            btn_rise;
    logic            illegal;

`ifdef PED_FLASH_EN
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    logic [FW-1:0]   flash_cnt;
    logic            flash_q;
`endif

    assign red_now  = (lights == L_RED);
    assign red_rise = red_now && (lights_q != L_RED);
    assign btn_rise = btn_s2 && !btn_s3;

    always_comb begin
        illegal = 1'b1;
        case (lights)
            L_RED, L_RED_YELLOW, L_GREEN, L_YELLOW: illegal = 1'b0;
            default:                                illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_DONT_WALK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_DONT_WALK: begin
                if (red_rise && (req || btn_rise)) state_nxt = S_WALK;
            end
            S_WALK: begin
                if (!red_now)            state_nxt = S_DONT_WALK;
                else if (timer == '0)    state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (!red_now || timer == '0) state_nxt = S_DONT_WALK;
            end
            default: state_nxt = S_DONT_WALK;
        endcase
    end

    always_comb begin
        walk_q      = 1'b0;
        dont_walk_q = 1'b1;
        case (state)
            S_WALK: begin
                walk_q      = 1'b1;
                dont_walk_q = 1'b0;
            end
            S_CLEAR: begin
`ifdef PED_FLASH_EN
                dont_walk_q = flash_q;
`else
                dont_walk_q = 1'b1;
`endif
            end
            default: begin
                walk_q      = 1'b0;
                dont_walk_q = 1'b1;
            end
        endcase
    end

    // Phase timer counts down and reloads on each phase entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else begin
            case (state)
                S_DONT_WALK: begin
                    if (state_nxt == S_WALK) timer <= TW'(WALK_TICKS - 1);
                end
                S_WALK: begin
                    if (state_nxt == S_CLEAR)     timer <= TW'(CLEAR_TICKS - 1);
                    else if (state_nxt == S_WALK) timer <= timer - TW'(1);
                    else                          timer <= '0;
                end
                S_CLEAR: begin
                    if (state_nxt == S_CLEAR) timer <= timer - TW'(1);
                    else                      timer <= '0;
                end
                default: timer <= '0;
            endcase
        end
    end

`ifdef PED_FLASH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_cnt <= '0;
            flash_q   <= 1'b1;
        end else if (state == S_WALK && state_nxt == S_CLEAR) begin
            flash_cnt <= FW'(FLASH_HALF - 1);
            flash_q   <= 1'b1;
        end else if (state == S_CLEAR) begin
            if (flash_cnt == '0) begin
                flash_cnt <= FW'(FLASH_HALF - 1);
                flash_q   <= !flash_q;
            end else begin
                flash_cnt <= flash_cnt - FW'(1);
            end
        end
    end
`endif

    // lights_q resets to RED so a RED already present at release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_s3   <= 1'b0;
            lights_q <= L_RED;
            req      <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            btn_s1   <= ped_btn;
            btn_s2   <= btn_s1;
            btn_s3   <= btn_s2;
            lights_q <= lights;
            if (state == S_DONT_WALK && state_nxt == S_WALK) begin
                req <= 1'b0;
            end else if (btn_rise && state != S_WALK) begin
                req <= 1'b1;
            end
            if (illegal) fault_q <= 1'b1;
        end
    end

    assign walk      = walk_q && red_now;
    assign dont_walk = dont_walk_q || !red_now;
    assign ped_wait  = req;
    assign fault     = fault_q;

endmodule

// File: tb/tb_pedestrian_signal_controller.sv
// Directed bench for pedestrian_signal_controller with short phase timings.
module tb_pedestrian_signal_controller;

    localparam int WT = 8;
    localparam int CT = 6;
    localparam int FH = 2;
    localparam int TWID = 4;

`ifdef PED_FLASH_EN
    localparam logic [0:5] CLR_PAT = 6'b110011;
`else
    localparam logic [0:5] CLR_PAT = 6'b111111;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lights;
    logic       ped_btn;
    logic       walk;
    logic       dont_walk;
    logic       ped_wait;
    logic       fault;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pedestrian_signal_controller #(
        .WALK_TICKS (WT),
        .CLEAR_TICKS(CT),
        .FLASH_HALF (FH),
        .TW         (TWID)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lights   (lights),
        .ped_btn  (ped_btn),
        .walk     (walk),
        .dont_walk(dont_walk),
        .ped_wait (ped_wait),
        .fault    (fault)
    );

    task automatic test_reset();
        rst = 1'b0;
        lights = 3'b100;
        ped_btn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({walk, dont_walk, ped_wait, fault} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_active: got %b expected 0100", {walk, dont_walk, ped_wait, fault});
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait, fault} !== 4'b0100) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b expected 0100", i, {walk, dont_walk, ped_wait, fault});
            end
        end
    endtask

    task automatic test_walk_cycle();
        lights = 3'b001;
        repeat (2) @(negedge clk);
        ped_btn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++;
            if (ped_wait !== (i >= 3)) begin
                errors++;
                $display("FAIL wait_latency edge %0d: got %b expected %b", i, ped_wait, (i >= 3));
            end
        end
        repeat (2) @(negedge clk);
        ped_btn = 1'b0;
        lights = 3'b010;
        repeat (2) @(negedge clk);
        lights = 3'b100;
        #1;
        vectors++;
        if ({walk, dont_walk} !== 2'b01) begin
            errors++;
            $display("FAIL red_entry_pre_edge: got %b expected 01", {walk, dont_walk});
        end
        for (int i = 0; i < WT; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b100) begin
                errors++;
                $display("FAIL walk_phase cycle %0d: got %b expected 100", i, {walk, dont_walk, ped_wait});
            end
        end
        for (int i = 0; i < CT; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk} !== {1'b0, CLR_PAT[i]}) begin
                errors++;
                $display("FAIL clear_phase cycle %0d: got %b expected %b", i, {walk, dont_walk}, {1'b0, CLR_PAT[i]});
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b010) begin
                errors++;
                $display("FAIL post_clear cycle %0d: got %b expected 010", i, {walk, dont_walk, ped_wait});
            end
        end
    endtask

    task automatic test_abort();
        lights = 3'b001;
        ped_btn = 1'b1;
        repeat (2) @(negedge clk);
        ped_btn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ped_wait !== 1'b1) begin
            errors++;
            $display("FAIL abort_req: got %b expected 1", ped_wait);
        end
        lights = 3'b100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk} !== 2'b10) begin
                errors++;
                $display("FAIL abort_walk cycle %0d: got %b expected 10", i, {walk, dont_walk});
            end
        end
        @(negedge clk);
        lights = 3'b001;
        #1;
        vectors++;
        if ({walk, dont_walk} !== 2'b01) begin
            errors++;
            $display("FAIL abort_same_cycle: got %b expected 01", {walk, dont_walk});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b010) begin
                errors++;
                $display("FAIL abort_green cycle %0d: got %b expected 010", i, {walk, dont_walk, ped_wait});
            end
        end
        lights = 3'b100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b010) begin
                errors++;
                $display("FAIL abort_no_clear cycle %0d: got %b expected 010", i, {walk, dont_walk, ped_wait});
            end
        end
    endtask

    task automatic test_btn_walk_clear();
        lights = 3'b001;
        ped_btn = 1'b1;
        repeat (2) @(negedge clk);
        ped_btn = 1'b0;
        repeat (3) @(negedge clk);
        lights = 3'b100;
        for (int i = 1; i <= WT; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b100) begin
                errors++;
                $display("FAIL btn_in_walk cycle %0d: got %b expected 100", i, {walk, dont_walk, ped_wait});
            end
            if (i == 2) ped_btn = 1'b1;
            if (i == 4) ped_btn = 1'b0;
        end
        for (int i = 1; i <= CT; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== {1'b0, CLR_PAT[i-1], (i >= 4)}) begin
                errors++;
                $display("FAIL btn_in_clear cycle %0d: got %b expected %b", i,
                         {walk, dont_walk, ped_wait}, {1'b0, CLR_PAT[i-1], (i >= 4)});
            end
            if (i == 1) ped_btn = 1'b1;
            if (i == 3) ped_btn = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b011) begin
                errors++;
                $display("FAIL pending_after_clear cycle %0d: got %b expected 011", i, {walk, dont_walk, ped_wait});
            end
        end
        lights = 3'b001;
        repeat (2) @(negedge clk);
        lights = 3'b100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b100) begin
                errors++;
                $display("FAIL grant_next_red cycle %0d: got %b expected 100", i, {walk, dont_walk, ped_wait});
            end
        end
        lights = 3'b001;
        @(negedge clk);
        vectors++;
        if ({walk, dont_walk, ped_wait} !== 3'b010) begin
            errors++;
            $display("FAIL grant_abort: got %b expected 010", {walk, dont_walk, ped_wait});
        end
    endtask

    task automatic test_fault();
        vectors++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_pre: got %b expected 0", fault);
        end
        lights = 3'b111;
        #1;
        vectors++;
        if ({walk, dont_walk, fault} !== 3'b010) begin
            errors++;
            $display("FAIL fault_illegal_cycle: got %b expected 010", {walk, dont_walk, fault});
        end
        @(negedge clk);
        vectors++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set: got %b expected 1", fault);
        end
        lights = 3'b100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, fault} !== 3'b011) begin
                errors++;
                $display("FAIL fault_sticky cycle %0d: got %b expected 011", i, {walk, dont_walk, fault});
            end
            if (i == 1) lights = 3'b001;
        end
    endtask

    task automatic test_reset_mid_walk();
        lights = 3'b001;
        ped_btn = 1'b1;
        repeat (2) @(negedge clk);
        ped_btn = 1'b0;
        repeat (3) @(negedge clk);
        lights = 3'b100;
        repeat (2) @(negedge clk);
        vectors++;
        if (walk !== 1'b1) begin
            errors++;
            $display("FAIL mid_walk_entry: got %b expected 1", walk);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({walk, dont_walk, ped_wait, fault} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid_walk: got %b expected 0100", {walk, dont_walk, ped_wait, fault});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait, fault} !== 4'b0100) begin
                errors++;
                $display("FAIL after_mid_reset cycle %0d: got %b expected 0100", i, {walk, dont_walk, ped_wait, fault});
            end
        end
        lights = 3'b001;
        ped_btn = 1'b1;
        repeat (2) @(negedge clk);
        ped_btn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (ped_wait !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_req: got %b expected 0", ped_wait);
        end
        @(negedge clk);
        rst = 1'b1;
        lights = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({walk, dont_walk, ped_wait} !== 3'b010) begin
                errors++;
                $display("FAIL lost_req_no_walk cycle %0d: got %b expected 010", i, {walk, dont_walk, ped_wait});
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk_cycle();
        test_abort();
        test_btn_walk_clear();
        test_fault();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
